// File: rtl/drum_sequencer.sv
// drum_sequencer: three-voice pattern-driven drum machine with saturated mix and sigma-delta output
module drum_sequencer #(
  parameter int SAMPLE_DIV_BITS = 10,
  parameter int TICK_BITS       = 12,
  parameter int STEPS           = 16,
  parameter int OUT_W           = 8,
  parameter int KICK_DECAY_SH   = 11,
  parameter int SNARE_DECAY_SH  = 12,
  parameter int HAT_DECAY_SH    = 9
) (
  input  logic                     clk48,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     pat_we,
  input  logic [1:0]               pat_voice,
  input  logic [$clog2(STEPS)-1:0] pat_step,
  input  logic                     pat_bit,
  input  logic [2:0]               mute,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     step_strobe,
  output logic [OUT_W-1:0]         audio_sample,
  output logic                     out
);
  localparam int SW = $clog2(STEPS);

  function automatic logic [STEPS-1:0] def_pat(input int v);
    logic [STEPS-1:0] p;
    p = '0;
    for (int s = 0; s < STEPS; s++)
      p[s] = (v == 0) ? (s % (STEPS/2) == 0) : (v == 1) ? (s % (STEPS/2) == STEPS/4) : (s % 2 == 0);
    return p;
  endfunction

  localparam logic [2:0][STEPS-1:0] PAT_RST = {def_pat(2), def_pat(1), def_pat(0)};
  localparam logic [OUT_W-1:0] MID = OUT_W'(8'h80) << (OUT_W - 8);
  localparam logic [14:0] KRND = 15'((1 << KICK_DECAY_SH) - 1);
  localparam logic [16:0] SRND = 17'((1 << SNARE_DECAY_SH) - 1);
  localparam logic [16:0] HRND = 17'((1 << HAT_DECAY_SH) - 1);

  logic [SAMPLE_DIV_BITS-1:0] div_q, div_d;
  logic [TICK_BITS-1:0]       tcnt_q, tcnt_d;
  logic [SW-1:0]              step_q, step_d;
  logic                       strobe_q, strobe_d, tickd_q, tickd_d;
  logic [2:0][STEPS-1:0]      pat_q, pat_d;
  logic [14:0]                lfsr_q, lfsr_d;
  logic [13:0]                kinc_q, kinc_d, kdec;
  logic [20:0]                kpos_q, kpos_d;
  logic [15:0]                senv_q, senv_d, sy1_q, sy1_d, henv_q, henv_d, sdec, hdec;
  logic [OUT_W-1:0]           sample_q, sample_d, acc_q, acc_d;
  logic                       out_q, out_d;
  logic                       tick, adv, fire;
  logic [2:0]                 trig;
  logic [13:0]                sx14;
  logic [15:0]                ktri, sx, sdiff;
  logic [7:0]                 kick_out, snare_out, hat_mag, hat_out, km, sm, hm, mix8;
  logic [9:0]                 sum;

  always_comb begin
    tick = div_q == '0;
    adv = tick && run;
    fire = adv && tcnt_q == '0;
    trig = {pat_q[2][step_q], pat_q[1][step_q], pat_q[0][step_q]} & ~mute & {3{fire}};
    div_d = div_q + 1'b1;
    tcnt_d = adv ? tcnt_q + 1'b1 : tcnt_q;
    step_d = (adv && tcnt_q == '1) ? step_q + 1'b1 : step_q;
    strobe_d = fire;
    tickd_d = tick;
    pat_d = pat_q;
    if (pat_we && pat_voice != 2'd3) pat_d[pat_voice][pat_step] = pat_bit;
    lfsr_d = tick ? {lfsr_q[0], lfsr_q[0] ^ lfsr_q[14], lfsr_q[13:1]} : lfsr_q;
    ktri = (kpos_q[20:5] ^ {16{kpos_q[20]}}) - 16'd16384;
    kick_out = (kinc_q == '0) ? 8'd0 : 8'(ktri >> 8);
    sx14 = senv_q[15:2] & lfsr_q[13:0];
    sx = {{2{sx14[13]}}, sx14};
    sdiff = sx - sy1_q;
    snare_out = 8'(sdiff >> 8);
    hat_mag = {1'b0, henv_q[15:9]};
    hat_out = lfsr_q[0] ? hat_mag : 8'd0 - hat_mag;
    km = mute[0] ? 8'd0 : kick_out;
    sm = mute[1] ? 8'd0 : snare_out;
    hm = mute[2] ? 8'd0 : hat_out;
    sum = {{2{km[7]}}, km} + {{2{sm[7]}}, sm} + {{2{hm[7]}}, hm};
    mix8 = ($signed(sum) > 10'sd127) ? 8'h7F : ($signed(sum) < -10'sd128) ? 8'h80 : sum[7:0];
    sample_d = tickd_q ? OUT_W'(mix8 ^ 8'h80) << (OUT_W - 8) : sample_q;
    {out_d, acc_d} = {1'b0, acc_q} + {1'b0, sample_q};
    kdec = 14'(({1'b0, kinc_q} + KRND) >> KICK_DECAY_SH);
    kinc_d = trig[0] ? 14'h3FFF : tick ? kinc_q - kdec : kinc_q;
    kpos_d = trig[0] ? 21'd0 : tick ? kpos_q + {7'd0, kinc_q} : kpos_q;
    sdec = 16'(({1'b0, senv_q} + SRND) >> SNARE_DECAY_SH);
    senv_d = trig[1] ? 16'hFFFF : tick ? senv_q - sdec : senv_q;
    sy1_d = trig[1] ? 16'd0 : tick ? sx + {{9{snare_out[7]}}, snare_out[7:1]} : sy1_q;
    hdec = 16'(({1'b0, henv_q} + HRND) >> HAT_DECAY_SH);
    henv_d = trig[2] ? 16'hFFFF : tick ? henv_q - hdec : henv_q;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      tcnt_q <= '0;
      step_q <= '0;
      strobe_q <= 1'b0;
      tickd_q <= 1'b0;
      pat_q <= PAT_RST;
      lfsr_q <= 15'h1CAF;
      kinc_q <= '0;
      kpos_q <= '0;
      senv_q <= '0;
      sy1_q <= '0;
      henv_q <= '0;
      sample_q <= MID;
      acc_q <= '0;
      out_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tcnt_q <= tcnt_d;
      step_q <= step_d;
      strobe_q <= strobe_d;
      tickd_q <= tickd_d;
      pat_q <= pat_d;
      lfsr_q <= lfsr_d;
      kinc_q <= kinc_d;
      kpos_q <= kpos_d;
      senv_q <= senv_d;
      sy1_q <= sy1_d;
      henv_q <= henv_d;
      sample_q <= sample_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign step = step_q;
  assign step_strobe = strobe_q;
  assign audio_sample = sample_q;
  assign out = out_q;
endmodule

// File: tb/tb_drum_sequencer.sv
// tb_drum_sequencer: directed checks plus a cycle model of the sequencer, voices and mix
module tb_drum_sequencer;
  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       pat_we = 1'b0;
  logic [1:0] pat_voice = '0;
  logic [3:0] pat_step = '0;
  logic       pat_bit = 1'b0;
  logic [2:0] mute = '0;
  logic [3:0] step;
  logic       step_strobe;
  logic [7:0] audio_sample;
  logic       out;
  int         n_vec = 0;
  int         n_bad = 0;
  bit         mdl_on = 1'b0;
  int m_div, m_tcnt, m_step, m_strobe, m_tickd, m_sample, m_acc, m_out;
  int m_lfsr, m_kinc, m_kpos, m_senv, m_sy1, m_henv;
  bit m_pat[3][16];

  drum_sequencer #(.SAMPLE_DIV_BITS(2), .TICK_BITS(3), .STEPS(16), .OUT_W(8)) dut (
    .clk48(clk48), .rst_n(rst_n), .run(run), .pat_we(pat_we), .pat_voice(pat_voice),
    .pat_step(pat_step), .pat_bit(pat_bit), .mute(mute), .step(step),
    .step_strobe(step_strobe), .audio_sample(audio_sample), .out(out)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int kick_o(int inc, int pos);
    int t;
    if (inc == 0) return 0;
    t = (pos >> 5) & 'hFFFF;
    if (pos >= 'h100000) t = t ^ 'hFFFF;
    t = ((t - 16384) & 'hFFFF) >> 8;
    return t >= 128 ? t - 256 : t;
  endfunction

  function automatic int snare_x(int env, int lf);
    int x;
    x = (env >> 2) & lf & 'h3FFF;
    return x >= 8192 ? x - 16384 : x;
  endfunction

  function automatic int snare_o(int x, int y1);
    int d;
    d = ((x - y1) & 'hFFFF) >> 8;
    return d >= 128 ? d - 256 : d;
  endfunction

  function automatic int wrap16(int v);
    int w;
    w = v & 'hFFFF;
    return w >= 'h8000 ? w - 'h10000 : w;
  endfunction

  task automatic mdl_reset();
    m_div = 0; m_tcnt = 0; m_step = 0; m_strobe = 0; m_tickd = 0;
    m_sample = 'h80; m_acc = 0; m_out = 0; m_lfsr = 'h1CAF;
    m_kinc = 0; m_kpos = 0; m_senv = 0; m_sy1 = 0; m_henv = 0;
    for (int s = 0; s < 16; s++) begin
      m_pat[0][s] = (s % 8 == 0);
      m_pat[1][s] = (s % 8 == 4);
      m_pat[2][s] = (s % 2 == 0);
    end
  endtask

  always @(posedge clk48 or negedge rst_n) begin : mdl
    int tk, fire, k, so, sn, x, h, sum, sd, nl;
    bit [2:0] trg;
    if (!rst_n) mdl_reset();
    else begin
      tk = (m_div == 0);
      fire = tk && run && m_tcnt == 0;
      for (int v = 0; v < 3; v++) trg[v] = fire && m_pat[v][m_step] && !mute[v];
      k = mute[0] ? 0 : kick_o(m_kinc, m_kpos);
      x = snare_x(m_senv, m_lfsr);
      so = snare_o(x, m_sy1);
      sn = mute[1] ? 0 : so;
      h = mute[2] ? 0 : ((m_lfsr & 1) ? (m_henv >> 9) : -(m_henv >> 9));
      sum = k + sn + h;
      if (sum > 127) sum = 127;
      if (sum < -128) sum = -128;
      sd = m_acc + m_sample;
      m_out = sd >> 8;
      m_acc = sd & 255;
      if (m_tickd) m_sample = (sum & 255) ^ 128;
      m_tickd = tk;
      m_strobe = fire;
      if (tk) begin
        nl = ((m_lfsr & 1) << 14) | ((((m_lfsr & 1) ^ (m_lfsr >> 14)) & 1) << 13) | ((m_lfsr >> 1) & 'h1FFF);
        if (trg[0]) begin m_kinc = 'h3FFF; m_kpos = 0; end
        else begin m_kpos = (m_kpos + m_kinc) & 'h1FFFFF; m_kinc = m_kinc - ((m_kinc + 2047) >> 11); end
        if (trg[1]) begin m_senv = 'hFFFF; m_sy1 = 0; end
        else begin m_senv = m_senv - ((m_senv + 4095) >> 12); m_sy1 = wrap16(x + (so >>> 1)); end
        if (trg[2]) m_henv = 'hFFFF;
        else m_henv = m_henv - ((m_henv + 511) >> 9);
        m_lfsr = nl;
      end
      if (tk && run) begin
        if (m_tcnt == 7) m_step = (m_step + 1) % 16;
        m_tcnt = (m_tcnt + 1) % 8;
      end
      if (pat_we && pat_voice != 2'd3) m_pat[pat_voice][pat_step] = pat_bit;
      m_div = (m_div + 1) % 4;
    end
  end

  always begin
    @(negedge clk48);
    #1;
    if (mdl_on) begin
      chk("mdl_sample", audio_sample, m_sample);
      chk("mdl_out", out, m_out);
      chk("mdl_step", step, m_step);
      chk("mdl_strobe", step_strobe, m_strobe);
    end
  end

  task automatic do_reset(input logic r);
    @(negedge clk48);
    rst_n = 1'b0;
    #1;
    chk("rst_sample", audio_sample, 8'h80);
    chk("rst_step", step, 0);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_kinc", dut.kinc_q, 0);
    chk("rst_henv", dut.henv_q, 0);
    chk("rst_out", out, 0);
    @(negedge clk48);
    run = r;
    rst_n = 1'b1;
  endtask

  task automatic wr(input int v, input int s, input logic b);
    pat_we = 1'b1; pat_voice = 2'(v); pat_step = 4'(s); pat_bit = b;
    @(negedge clk48);
    pat_we = 1'b0;
  endtask

  initial begin
    logic [13:0] kh;
    do_reset(1'b0);
    mdl_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk48);
      chk("sd_silence", out, i % 2);
    end
    repeat (40) @(negedge clk48);
    chk("idle_sample", audio_sample, 8'h80);
    chk("idle_step", step, 0);

    do_reset(1'b1);
    @(negedge clk48);
    chk("strobe_c1", step_strobe, 1);
    chk("kick_trig", dut.kinc_q, 14'h3FFF);
    chk("hat_trig_s0", dut.henv_q, 16'hFFFF);
    chk("snare_idle_s0", dut.senv_q, 0);
    @(negedge clk48);
    chk("strobe_1cyc", step_strobe, 0);
    repeat (3) @(negedge clk48);
    chk("kick_dec", dut.kinc_q, 14'h3FF7);
    repeat (23) @(negedge clk48);
    chk("step0_hold", step, 0);
    @(negedge clk48);
    chk("step1", step, 1);
    repeat (4) @(negedge clk48);
    chk("strobe_s1", step_strobe, 1);
    repeat (96) @(negedge clk48);
    chk("snare_s4_step", step, 4);
    chk("snare_s4_env", dut.senv_q, 16'hFFFF);

    mute = 3'b001;
    do_reset(1'b1);
    @(negedge clk48);
    chk("mute_k_s0", dut.kinc_q, 0);
    chk("mute_strobe", step_strobe, 1);
    repeat (128) @(negedge clk48);
    chk("mute_snare_s4", dut.senv_q, 16'hFFFF);
    repeat (128) @(negedge clk48);
    chk("mute_step8", step, 8);
    chk("mute_k_s8", dut.kinc_q, 0);
    mute = 3'b000;

    do_reset(1'b0);
    for (int v = 0; v < 3; v++)
      for (int s = 0; s < 16; s++) wr(v, s, 1'b0);
    wr(2, 3, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 400 && !(m_div == 0 && m_tcnt == 0 && m_step == 3); i++) begin
      @(negedge clk48);
      if (step < 3) chk("quiet_s0_2", audio_sample, 8'h80);
    end
    pat_we = 1'b1; pat_voice = 2'd2; pat_step = 4'd3; pat_bit = 1'b0;
    @(negedge clk48);
    pat_we = 1'b0;
    chk("hat_trig_step", step, 3);
    chk("hat_old_bit", dut.henv_q, 16'hFFFF);
    chk("hat_only_kick", dut.kinc_q, 0);
    chk("hat_only_snare", dut.senv_q, 0);
    @(negedge clk48);
    for (int i = 0; i < 600 && !(m_div == 0 && m_tcnt == 0 && m_step == 3); i++) @(negedge clk48);
    @(negedge clk48);
    chk("hat_s3_again", step, 3);
    chk("hat_cleared", dut.henv_q != 16'hFFFF, 1);
    chk("hat_env_mdl", dut.henv_q, m_henv);

    do_reset(1'b0);
    wr(1, 0, 1'b1);
    run = 1'b1;
    repeat (1100) @(negedge clk48);

    for (int i = 0; i < 600 && (step == 5 && dut.tcnt_q == 2); i++) @(negedge clk48);
    for (int i = 0; i < 600 && !(step == 5 && dut.tcnt_q == 2); i++) @(negedge clk48);
    chk("hold_found", step, 5);
    kh = dut.kinc_q;
    run = 1'b0;
    repeat (100) @(negedge clk48);
    chk("hold_step", step, 5);
    chk("hold_tcnt", dut.tcnt_q, 2);
    chk("hold_decay", dut.kinc_q < kh, 1);
    chk("hold_kinc_mdl", dut.kinc_q, m_kinc);
    run = 1'b1;
    repeat (23) @(negedge clk48);
    chk("resume_s5", step, 5);
    @(negedge clk48);
    chk("resume_s6", step, 6);
    repeat (3) @(negedge clk48);
    chk("resume_nostrobe", step_strobe, 0);
    @(negedge clk48);
    chk("resume_strobe", step_strobe, 1);

    repeat (2) @(negedge clk48);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
